// File: rtl/ext_unit_pipe.sv
// ext_unit_pipe: extends an IN_W-bit field to OUT_W bits (zero-extend,
// sign-extend, upper-place or bit-replicate) and holds the computed results
// in a 2-entry FIFO with valid/ready handshakes on both sides.
// Optional build macro: EXT_STATS_EN adds a 16-bit saturating pop counter
// (op_count). Without it the port and the counter logic do not exist.
module ext_unit_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef EXT_STATS_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam int PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Flags come from the occupancy register only, so out_ready never
    // reaches in_ready combinationally; a full buffer refuses pushes even
    // when a pop happens in the same cycle.
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Extension is done before storage so the buffer only holds final results.
    always_comb begin
        ext_data = '0;
        case (in_mode)
            2'b00:   ext_data = {{PAD_W{1'b0}}, in_data};
            2'b01:   ext_data = {{PAD_W{in_data[IN_W-1]}}, in_data};
            2'b10:   ext_data = {in_data, {PAD_W{1'b0}}};
            default: ext_data = {OUT_W{in_data[0]}};
        endcase
    end

    // Storage write; entries are cleared on reset so out_data reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= ext_data;
        end
    end

    // Circular pointers (1-bit, wrap 1->0 naturally) and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef EXT_STATS_EN
    // Pop counter, saturating at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 16'd0;
        end else if (pop && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// Self-checking bench for ext_unit_pipe: scoreboard queue of expected results
// plus an occupancy model for in_ready/out_valid. Build with EXT_STATS_EN
// defined to also exercise op_count.
module tb_ext_unit_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic [1:0]  m;
        logic        r;
        logic [31:0] e;
    } stim_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    logic             n_in_valid;
    logic             n_in_ready;
    logic [0:0]       n_in_data;
    logic [1:0]       n_in_mode;
    logic             n_out_valid;
    logic             n_out_ready;
    logic [31:0]      n_out_data;

`ifdef EXT_STATS_EN
    logic [15:0]      op_count;
    logic [15:0]      n_op_count;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          mcnt     = 0;
    logic [31:0] exp_q [$];
    stim_t       sq [$];

    always #5 clk = ~clk;

    ext_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef EXT_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    ext_unit_pipe #(.IN_W(1), .OUT_W(32)) dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .in_mode   (n_in_mode),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data)
`ifdef EXT_STATS_EN
        ,
        .op_count  (n_op_count)
`endif
    );

    // Bit-by-bit reference for the four extension modes.
    function automatic logic [31:0] model(input logic [15:0] d, input logic [1:0] m);
        logic [31:0] r;
        int          k;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            k = i % 16;
            case (m)
                2'b00:   r[i] = (i < 16) ? d[k] : 1'b0;
                2'b01:   r[i] = (i < 16) ? d[k] : d[15];
                2'b10:   r[i] = (i >= 16) ? d[k] : 1'b0;
                default: r[i] = d[0];
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_in_mode = 2'b00; n_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
        checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL reset_n_out_valid got=%b exp=0", n_out_valid); end
`ifdef EXT_STATS_EN
        checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL reset_op_count got=%h exp=0000", op_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0;
        exp_q.delete();
    endtask

    // Directed mode vectors streamed at full rate, then random traffic.
    task automatic test_modes();
        logic pushed, popped;
        sq.delete();
        sq.push_back('{1'b1, 16'h8001, 2'b01, 1'b1, 32'hFFFF8001});
        sq.push_back('{1'b1, 16'h8001, 2'b00, 1'b1, 32'h00008001});
        sq.push_back('{1'b1, 16'h1234, 2'b10, 1'b1, 32'h12340000});
        sq.push_back('{1'b1, 16'h0001, 2'b11, 1'b1, 32'hFFFFFFFF});
        sq.push_back('{1'b1, 16'h0000, 2'b11, 1'b1, 32'h00000000});
        sq.push_back('{1'b1, 16'h7FFE, 2'b01, 1'b1, 32'h00007FFE});
        for (int i = 0; i < 30; i++) begin
            stim_t s;
            s.v = 1'($urandom_range(0, 1));
            s.d = 16'($urandom);
            s.m = 2'($urandom_range(0, 3));
            s.r = ($urandom_range(0, 3) != 0);
            s.e = model(s.d, s.m);
            sq.push_back(s);
        end
        repeat (4) sq.push_back('{1'b0, 16'h0, 2'b00, 1'b1, 32'h0});
        foreach (sq[c]) begin
            @(negedge clk);
            in_valid = sq[c].v; in_data = sq[c].d; in_mode = sq[c].m; out_ready = sq[c].r;
            #1;
            checks++; if (in_ready !== (mcnt < 2)) begin failures++; $display("FAIL modes_in_ready cyc=%0d got=%b exp=%b", c, in_ready, (mcnt < 2)); end
            checks++; if (out_valid !== (mcnt != 0)) begin failures++; $display("FAIL modes_out_valid cyc=%0d got=%b exp=%b", c, out_valid, (mcnt != 0)); end
            if (mcnt != 0) begin
                checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL modes_out_data cyc=%0d got=%h exp=%h", c, out_data, exp_q[0]); end
            end
            pushed = in_valid && (mcnt < 2);
            popped = out_ready && (mcnt != 0);
            if (popped) void'(exp_q.pop_front());
            if (pushed) exp_q.push_back(sq[c].e);
            mcnt = mcnt + int'(pushed) - int'(popped);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL modes_drain out_valid=%b left=%0d exp 0/0", out_valid, exp_q.size()); end
    endtask

    // A,B accepted with out_ready low, C refused while full (also while a pop
    // occurs), then everything drains in order.
    task automatic test_backpressure();
        logic pushed, popped;
        sq.delete();
        sq.push_back('{1'b1, 16'hAAAA, 2'b00, 1'b0, 32'h0000AAAA});
        sq.push_back('{1'b1, 16'h5555, 2'b01, 1'b0, 32'h00005555});
        sq.push_back('{1'b1, 16'hC003, 2'b01, 1'b0, 32'hFFFFC003});
        sq.push_back('{1'b1, 16'hC003, 2'b01, 1'b0, 32'hFFFFC003});
        sq.push_back('{1'b1, 16'hC003, 2'b01, 1'b0, 32'hFFFFC003});
        sq.push_back('{1'b1, 16'hC003, 2'b01, 1'b1, 32'hFFFFC003});
        sq.push_back('{1'b1, 16'hC003, 2'b01, 1'b1, 32'hFFFFC003});
        sq.push_back('{1'b0, 16'h0000, 2'b00, 1'b1, 32'h0});
        sq.push_back('{1'b0, 16'h0000, 2'b00, 1'b1, 32'h0});
        foreach (sq[c]) begin
            @(negedge clk);
            in_valid = sq[c].v; in_data = sq[c].d; in_mode = sq[c].m; out_ready = sq[c].r;
            #1;
            checks++; if (in_ready !== (mcnt < 2)) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", c, in_ready, (mcnt < 2)); end
            checks++; if (out_valid !== (mcnt != 0)) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", c, out_valid, (mcnt != 0)); end
            if (mcnt != 0) begin
                checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL bp_out_data cyc=%0d got=%h exp=%h", c, out_data, exp_q[0]); end
            end
            pushed = in_valid && (mcnt < 2);
            popped = out_ready && (mcnt != 0);
            if (popped) void'(exp_q.pop_front());
            if (pushed) exp_q.push_back(sq[c].e);
            mcnt = mcnt + int'(pushed) - int'(popped);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL bp_drain out_valid=%b left=%0d exp 0/0", out_valid, exp_q.size()); end
    endtask

    // Hold occupancy at 1 with simultaneous push/pop; pointers wrap repeatedly.
    task automatic test_back_to_back();
        logic pushed, popped;
        sq.delete();
        sq.push_back('{1'b1, 16'h0101, 2'b00, 1'b0, 32'h00000101});
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            d = 16'hF000 | 16'(i);
            sq.push_back('{1'b1, d, 2'b01, 1'b1, {16'hFFFF, d}});
        end
        sq.push_back('{1'b0, 16'h0, 2'b00, 1'b1, 32'h0});
        sq.push_back('{1'b0, 16'h0, 2'b00, 1'b1, 32'h0});
        foreach (sq[c]) begin
            @(negedge clk);
            in_valid = sq[c].v; in_data = sq[c].d; in_mode = sq[c].m; out_ready = sq[c].r;
            #1;
            checks++; if (in_ready !== (mcnt < 2)) begin failures++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", c, in_ready, (mcnt < 2)); end
            checks++; if (out_valid !== (mcnt != 0)) begin failures++; $display("FAIL b2b_out_valid cyc=%0d got=%b exp=%b", c, out_valid, (mcnt != 0)); end
            if (mcnt != 0) begin
                checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL b2b_out_data cyc=%0d got=%h exp=%h", c, out_data, exp_q[0]); end
            end
            pushed = in_valid && (mcnt < 2);
            popped = out_ready && (mcnt != 0);
            if (popped) void'(exp_q.pop_front());
            if (pushed) exp_q.push_back(sq[c].e);
            mcnt = mcnt + int'(pushed) - int'(popped);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain out_valid=%b left=%0d exp 0/0", out_valid, exp_q.size()); end
    endtask

    // Asynchronous reset with a full buffer, then no stale output, then a
    // push accepted on the first edge after release.
    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h1111; in_mode = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        in_data = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin failures++; $display("FAIL rmid_full in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL rmid_out_data got=%h exp=00000000", out_data); end
        exp_q.delete();
        mcnt = 0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale cyc=%0d out_valid=%b exp=0", i, out_valid); end
        end
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b1; in_data = 16'h00F0; in_mode = 2'b10; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_first_push out_valid=%b exp=1", out_valid); end
        checks++; if (out_data !== 32'h00F00000) begin failures++; $display("FAIL rmid_first_data got=%h exp=00F00000", out_data); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_final out_valid=%b exp=0", out_valid); end
    endtask

    // IN_W=1 instance: every mode with a single-bit field.
    task automatic test_narrow();
        logic [0:0]  nd [6];
        logic [1:0]  nm [6];
        logic [31:0] ne [6];
        nd = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        nm = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11, 2'b01};
        ne = '{32'hFFFFFFFF, 32'h00000001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        n_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL narrow_idle i=%0d out_valid=%b exp=0", i, n_out_valid); end
            n_in_valid = 1'b1; n_in_data = nd[i]; n_in_mode = nm[i];
            @(negedge clk);
            n_in_valid = 1'b0;
            #1;
            checks++; if (n_out_valid !== 1'b1) begin failures++; $display("FAIL narrow_valid i=%0d got=%b exp=1", i, n_out_valid); end
            checks++; if (n_out_data !== ne[i]) begin failures++; $display("FAIL narrow_data i=%0d got=%h exp=%h", i, n_out_data, ne[i]); end
        end
        @(negedge clk);
        n_out_ready = 1'b0;
    endtask

`ifdef EXT_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL stats_clear got=%h exp=0000", op_count); end
        in_valid = 1'b1; in_data = 16'h0042; in_mode = 2'b00; out_ready = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (op_count !== 16'd5) begin failures++; $display("FAIL stats_five got=%0d exp=5", op_count); end
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (65540) @(negedge clk);
        #1;
        checks++; if (op_count !== 16'hFFFF) begin failures++; $display("FAIL stats_saturate got=%h exp=FFFF", op_count); end
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checks++; if (op_count !== 16'hFFFF) begin failures++; $display("FAIL stats_hold got=%h exp=FFFF", op_count); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mcnt = 0;
        exp_q.delete();
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_narrow();
`ifdef EXT_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
